// File: rtl/mpu_frame_assembler.sv
// Purpose: packs the 14-byte MPU burst into seven 16-bit words, calibrates gyro zero-offsets, then publishes corrected frames.
// Latency: frame_valid and words update 2 clocks after the byte_valid rise of the 14th byte; frame_err 1 clock after its cause.
// Backpressure: none; the byte stream is never stalled, and bad, late or extra bytes are dropped and flagged on frame_err.
// Ports: clk, rst_n (async active-low); byte_valid/byte_data from the I2C master (one byte per rising edge);
//        iic_busy (rising edge = new transaction, resynchronises); accel_x/y/z, temp raw; gyro_x/y/z offset-corrected;
//        frame_valid (1-cycle), cal_done (sticky), frame_err (1-cycle).
module mpu_frame_assembler #(
  parameter int CAL_LOG2   = 6,
  parameter int GAP_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        iic_busy,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        frame_valid,
  output logic        cal_done,
  output logic        frame_err
);

  localparam int AW = 16 + CAL_LOG2;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]       GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [CAL_LOG2:0]   CAL_FRAMES = {1'b1, {CAL_LOG2{1'b0}}};
  localparam logic [3:0]          IDX_FULL   = 4'd14;

  typedef enum logic {ST_CAL, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic                 bv_d_q, busy_d_q;
  logic [3:0]           idx_q, idx_d;
  logic [13:0][7:0]     shadow_q, shadow_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 err_q, err_d;
  logic                 complete_q, complete_d;
  logic [2:0][AW-1:0]   acc_q, acc_d;
  logic [2:0][15:0]     off_q, off_d;
  logic [CAL_LOG2:0]    fcnt_q, fcnt_d;
  logic [6:0][15:0]     word_q, word_d;
  logic                 fv_q, fv_d;
  logic                 cal_done_q, cal_done_d;

  logic byte_str, busy_rise;
  logic [6:0][15:0] raw;

  // Mean of the calibration sums; arithmetic shift rounds toward -inf.
  function automatic logic [15:0] avg(input logic [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = $signed(a) >>> CAL_LOG2;
    return s[15:0];
  endfunction

  // raw - off at 17 bits, clamped to the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic [15:0] r, input logic [15:0] o);
    logic [16:0] d;
    d = {r[15], r} - {o[15], o};
    if (d[16:15] == 2'b01)      return 16'h7FFF;
    else if (d[16:15] == 2'b10) return 16'h8000;
    else                        return d[15:0];
  endfunction

  assign byte_str  = byte_valid & ~bv_d_q;
  assign busy_rise = iic_busy & ~busy_d_q;

  // Big-endian: even shadow slot is the high byte.
  always_comb begin
    for (int k = 0; k < 7; k++) raw[k] = {shadow_q[2*k], shadow_q[2*k+1]};
  end

  always_comb begin
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    gap_d      = gap_q;
    err_d      = 1'b0;
    complete_d = 1'b0;
    state_d    = state_q;
    acc_d      = acc_q;
    off_d      = off_q;
    fcnt_d     = fcnt_q;
    word_d     = word_q;
    fv_d       = 1'b0;
    cal_done_d = cal_done_q;

    // Byte framing; a new transaction outranks a byte, a byte outranks the gap timeout.
    if (busy_rise) begin
      err_d = (idx_q != 4'd0) && (idx_q != IDX_FULL);
      gap_d = '0;
      if (byte_str) begin
        shadow_d[0] = byte_data;
        idx_d       = 4'd1;
      end else begin
        idx_d       = 4'd0;
      end
    end else if (byte_str) begin
      gap_d = '0;
      if (idx_q == IDX_FULL) begin
        err_d = 1'b1;
      end else begin
        shadow_d[idx_q] = byte_data;
        idx_d           = idx_q + 4'd1;
        complete_d      = (idx_q == 4'd13);
      end
    end else if ((idx_q != 4'd0) && (idx_q != IDX_FULL)) begin
      if (gap_q == GAP_LAST) begin
        err_d = 1'b1;
        idx_d = 4'd0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end else begin
      gap_d = '0;
    end

    // Calibration / run sequencing on each completed frame.
    case (state_q)
      ST_CAL: begin
        if (complete_q) begin
          for (int g = 0; g < 3; g++)
            acc_d[g] = acc_q[g] + {{CAL_LOG2{raw[4+g][15]}}, raw[4+g]};
          fcnt_d = fcnt_q + 1'b1;
        end
        // Evaluated the cycle after the last accumulate, so acc_q holds all frames.
        if (fcnt_q == CAL_FRAMES) begin
          for (int g = 0; g < 3; g++) off_d[g] = avg(acc_q[g]);
          cal_done_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (complete_q) begin
          for (int k = 0; k < 4; k++) word_d[k] = raw[k];
          for (int g = 0; g < 3; g++) word_d[4+g] = sat16(raw[4+g], off_q[g]);
          fv_d = 1'b1;
        end
      end
      default: state_d = ST_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CAL;
      bv_d_q     <= 1'b0;
      busy_d_q   <= 1'b0;
      idx_q      <= 4'd0;
      shadow_q   <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      complete_q <= 1'b0;
      acc_q      <= '0;
      off_q      <= '0;
      fcnt_q     <= '0;
      word_q     <= '0;
      fv_q       <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bv_d_q     <= byte_valid;
      busy_d_q   <= iic_busy;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      complete_q <= complete_d;
      acc_q      <= acc_d;
      off_q      <= off_d;
      fcnt_q     <= fcnt_d;
      word_q     <= word_d;
      fv_q       <= fv_d;
      cal_done_q <= cal_done_d;
    end
  end

  assign accel_x     = word_q[0];
  assign accel_y     = word_q[1];
  assign accel_z     = word_q[2];
  assign temp        = word_q[3];
  assign gyro_x      = word_q[4];
  assign gyro_y      = word_q[5];
  assign gyro_z      = word_q[6];
  assign frame_valid = fv_q;
  assign cal_done    = cal_done_q;
  assign frame_err   = err_q;

endmodule

// File: doc/mpu_frame_assembler.md
# mpu_frame_assembler

Downstream consumer of the bit-banged I2C master's byte stream. Collects the 14-byte MPU burst (registers 0x3B–0x48), packs it into seven signed 16-bit words and calibrates a gyro zero-offset at start-up. Publishes one corrected sample set per complete frame to the attitude estimator. Detects truncated or over-long frames and resynchronises on every new I2C transaction.

## Interface
Parameters:
- CAL_LOG2, default 6: number of calibration frames is 2^CAL_LOG2 (64).
- GAP_CYCLES, default 50_000: idle clocks between bytes (1 ms @ 50 MHz) after which a partial frame is discarded.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  I2C master's data-valid; may be held high for several cycles; each rising edge is one byte.
- byte_data  in  8  I2C master's read data; sampled on the byte_valid rising edge.
- iic_busy  in  1  I2C master busy; a rising edge marks a new transaction.
- accel_x, accel_y, accel_z  out  16  signed raw accelerometer words.
- temp  out  16  signed raw temperature word.
- gyro_x, gyro_y, gyro_z  out  16  signed offset-corrected gyro words.
- frame_valid  out  1  one-cycle pulse when all seven words are updated.
- cal_done  out  1  high once gyro offsets are latched; stays high until reset.
- frame_err  out  1  one-cycle pulse on a discarded frame.

## Operation
- Byte strobe:
  - byte_str = byte_valid & ~byte_valid_d, with byte_valid_d registered.
  - Extra cycles of a held byte_valid are ignored.
- Byte index idx, 0..14:
  - On byte_str with idx < 14: byte goes to shadow[idx]; idx increments.
  - Even idx is the high byte and odd idx the low byte (big-endian).
  - Word order: AX, AY, AZ, T, GX, GY, GZ.
- Frame complete: the byte_str that stores idx 13 sets idx to 14.
- Over-long frame: byte_str at idx == 14 pulses frame_err; the byte is dropped and idx stays 14.
- Resync on iic_busy rising edge:
  - idx clears to 0.
  - If the old idx was neither 0 nor 14, frame_err pulses (truncated frame).
- Gap timer:
  - Counts clocks while 0 < idx < 14 with no byte_str; clears on any byte_str.
  - Reaching GAP_CYCLES pulses frame_err and clears idx to 0.
- States: CAL (after reset) and RUN.
- CAL:
  - Each complete frame adds raw GX, GY, GZ, sign-extended, into three accumulators of 16+CAL_LOG2 bits.
  - Frame counter fcnt has CAL_LOG2+1 bits.
  - When fcnt reaches 2^CAL_LOG2: off_g = acc >>> CAL_LOG2 (arithmetic shift, truncation toward −inf); cal_done sets; state goes to RUN.
  - No frame_valid in CAL; word outputs hold 0.
- RUN, per complete frame:
  - accel and temp are copied raw.
  - gyro = sat16(raw − off), computed at 17 bits and clamped to [−32768, 32767].
- Priority when events coincide in one cycle: reset > iic_busy rising edge > byte_str > gap timeout.
  - A byte_str coinciding with an iic_busy edge is stored as idx 0 of the new frame.
- Reset values: all word outputs 0, frame_valid 0, cal_done 0, frame_err 0, idx 0, accumulators 0, offsets 0, state CAL.
- Reset asserted mid-frame or mid-calibration discards everything and restarts in CAL.

## Timing
- Cycle N: byte_valid rises. N+1: byte_str registers the byte and idx updates.
- The 14th byte stored at N+1 means:
  - RUN: outputs update and frame_valid is high in N+2 only.
  - CAL: the accumulate happens in N+2. On the final calibration frame, cal_done rises in N+3.
- The first RUN frame_valid is for the frame after the last calibration frame.
- frame_err is high for exactly one cycle, registered one cycle after the triggering event.
- Minimum byte spacing is 2 clocks (byte_valid low for at least 1 clock); all bytes at that rate are accepted.
- Word outputs are stable between frame_valid pulses.

## Test plan
- Reset then idle: all outputs 0 and cal_done 0 for 1000 cycles.
- 64 frames with GX=0x0010, GY=0xFFF0, GZ=0x0000: cal_done rises after frame 64 and no frame_valid occurs during CAL. Then one frame AX=0x1234, T=0xF000, GX=0x0015:
  - frame_valid pulses once;
  - accel_x=0x1234, temp=0xF000, gyro_x=0x0005, gyro_y=0x0010 (raw 0x0000 − (−16)).
- Saturation: offset GX=+16, raw GX=0x8005 → gyro_x=0x8000. Offset GY=−16, raw GY=0x7FF5 → gyro_y=0x7FFF.
- Truncation: 9 bytes, then iic_busy rises → frame_err pulse, no frame_valid. The next full 14-byte frame gives frame_valid with correct words.
- byte_valid held 5 cycles per byte for a full frame → exactly 14 bytes counted, one frame_valid. A 15th byte before the next iic_busy edge → frame_err pulse with outputs unchanged.
- Gap and reset:
  - 4 bytes, then GAP_CYCLES idle → frame_err, idx 0.
  - rst_n asserted at calibration frame 30 → cal_done 0, and 64 further frames are needed.
